// File: rtl/lvl_gen.sv
// Purpose : converts single-cycle request pulses into a 4-phase lvl_sig/ack_sig handshake.
// Latency : lvl_sig rises one cycle after the sampled pulse and is held for at least MIN_HOLD cycles.
// Backpr. : none upstream; extra pulses are queued (LVL_GEN_PEND_QUEUE_EN) or dropped with drop_err.
//
// Ports:
//   clk        single clock, rising edge
//   RST        asynchronous active-low reset
//   pulse_sig  request pulse; each high cycle is one request
//   ack_sig    far-end acknowledge level
//   lvl_sig    request level, straight from a flop
//   busy       high while the state machine is not IDLE
//   drop_err   one-cycle pulse when a request is discarded
//   pend_cnt   queued requests not yet issued (tied to 0 without the queue)
//
// Build option: define LVL_GEN_PEND_QUEUE_EN to build the pending-request counter.
module lvl_gen #(
  parameter int unsigned MIN_HOLD = 4,
  parameter int unsigned PEND_W   = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              pulse_sig,
  input  logic              ack_sig,
  output logic              lvl_sig,
  output logic              busy,
  output logic              drop_err,
  output logic [PEND_W-1:0] pend_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [7:0] HOLD_INIT = 8'(MIN_HOLD - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       lvl_q, lvl_d;
  logic       busy_q, busy_d;
  logic       drop_q, drop_d;
  logic       start;

`ifdef LVL_GEN_PEND_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  logic [PEND_W-1:0] pend_q, pend_d;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lvl_d   = 1'b0;
    drop_d  = 1'b0;
    start   = 1'b0;
`ifdef LVL_GEN_PEND_QUEUE_EN
    pend_d  = pend_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef LVL_GEN_PEND_QUEUE_EN
        start = pulse_sig | (pend_q != '0);
        // A live pulse is served directly and leaves the queue alone;
        // only a queue-started transaction consumes an entry.
        if (!pulse_sig && (pend_q != '0)) begin
          pend_d = pend_q - PEND_W'(1);
        end
`else
        start = pulse_sig;
`endif
        if (start) begin
          state_d = ST_ASSERT;
          lvl_d   = 1'b1;
          hold_d  = HOLD_INIT;
        end
      end

      ST_ASSERT: begin
        // Release needs both the minimum hold spent and the far end's ack.
        if ((hold_q == 8'd0) && ack_sig) begin
          state_d = ST_RELEASE;
        end else begin
          lvl_d = 1'b1;
          if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
          end
        end
      end

      ST_RELEASE: begin
        if (!ack_sig) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        hold_d  = 8'd0;
      end
    endcase

    // Pulses outside IDLE (including the RELEASE->IDLE cycle) cannot start
    // a handshake now: queue them if possible, otherwise flag the loss.
    if ((state_q != ST_IDLE) && pulse_sig) begin
`ifdef LVL_GEN_PEND_QUEUE_EN
      if (pend_q == PEND_MAX) begin
        drop_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
`else
      drop_d = 1'b1;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      hold_q  <= 8'd0;
      lvl_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lvl_q   <= lvl_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

`ifdef LVL_GEN_PEND_QUEUE_EN
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
  assign pend_cnt = pend_q;
`else
  assign pend_cnt = '0;
`endif

  assign lvl_sig  = lvl_q;
  assign busy     = busy_q;
  assign drop_err = drop_q;

endmodule

// File: doc/lvl_gen.md
LVL_GEN -- requirements
Module: lvl_gen

Interface
REQ-001 Parameter MIN_HOLD, default 4, minimum cycles lvl_sig stays high per transaction; legal range 1..255.
REQ-002 Parameter PEND_W, default 4, width of the pending-request counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-low.
REQ-005 pulse_sig  input  1  single-cycle request pulse; each high cycle is one request.
REQ-006 ack_sig  input  1  acknowledge level from the far end; high means the request was seen, low means released.
REQ-007 lvl_sig  output  1  request level; registered.
REQ-008 busy  output  1  high whenever the state machine is not in IDLE; registered.
REQ-009 drop_err  output  1  single-cycle pulse when a request is discarded; registered.
REQ-010 pend_cnt  output  PEND_W  number of queued requests not yet issued; registered.

Function
REQ-011 The block SHALL turn request pulses into a 4-phase level handshake: lvl_sig up, ack_sig up, lvl_sig down, ack_sig down.
REQ-012 The state machine SHALL have the states IDLE, ASSERT and RELEASE.
REQ-013 IDLE: lvl_sig=0; if pulse_sig=1 or pend_cnt>0, go to ASSERT, set lvl_sig=1 and load the hold counter with MIN_HOLD-1.
REQ-014 lvl_sig SHALL rise on the clock edge that samples the pulse, one cycle of latency.
REQ-015 ASSERT: lvl_sig=1; the hold counter decrements each cycle, saturating at 0.
REQ-016 ASSERT->RELEASE SHALL happen only when hold counter==0 and ack_sig==1 are both true in the same cycle; lvl_sig=0 from that edge.
REQ-017 If ack_sig rises before the hold expires, the block SHALL stay in ASSERT until the hold expires.
REQ-018 If ack_sig stays low, the block SHALL stay in ASSERT indefinitely; there is no timeout.
REQ-019 RELEASE: lvl_sig=0; go to IDLE on the first cycle with ack_sig==0.
REQ-020 A transaction started from the queue (pulse_sig=0, pend_cnt>0) SHALL decrement pend_cnt by 1 on the same edge.
REQ-021 pulse_sig=1 in IDLE with pend_cnt>0 SHALL start one transaction and leave pend_cnt unchanged (+1 and -1 cancel).
REQ-022 pulse_sig=1 in ASSERT or RELEASE, including the RELEASE->IDLE cycle, SHALL increment pend_cnt.
REQ-023 pend_cnt SHALL saturate at 2^PEND_W-1; a pulse arriving at saturation SHALL be discarded and drive drop_err=1 for exactly one cycle.
REQ-024 busy SHALL equal (state != IDLE) and update on the same edge as the state.
REQ-025 lvl_sig SHALL be glitch-free: it is driven straight from a flop and never decoded from the state.

Reset
REQ-026 While RST=0, the block SHALL asynchronously force state=IDLE, lvl_sig=0, busy=0, drop_err=0, pend_cnt=0 and hold counter=0.
REQ-027 Reset mid-transaction SHALL abandon the transaction and discard all pending requests.
REQ-028 After RST goes high, the block SHALL accept a request on the first rising edge.

Configuration
REQ-029 The macro LVL_GEN_PEND_QUEUE_EN SHALL control the pending queue.
REQ-030 With LVL_GEN_PEND_QUEUE_EN defined, REQ-020..REQ-023 apply as written.
REQ-031 Without LVL_GEN_PEND_QUEUE_EN, pend_cnt SHALL be tied to 0 and no counter logic is built.
REQ-032 Without LVL_GEN_PEND_QUEUE_EN, every pulse_sig=1 while busy=1 SHALL be discarded and pulse drop_err=1 for one cycle.

Verification
REQ-033 MIN_HOLD=4; pulse at cycle 0; ack_sig high from cycle 2 -> lvl_sig high on cycles 1..4, low from cycle 5; after ack_sig falls, busy=0 one cycle later.
REQ-034 MIN_HOLD=1; pulse, ack_sig held low for 100 cycles -> lvl_sig stays high for all 100 cycles; no RELEASE.
REQ-035 Macro defined: three pulses while in ASSERT -> pend_cnt=3, and three more back-to-back handshakes follow, each decrementing pend_cnt.
REQ-036 Macro defined, PEND_W=2: five pulses while busy -> pend_cnt=3, drop_err pulses twice.
REQ-037 RST asserted while lvl_sig=1 and pend_cnt=2 -> lvl_sig, busy and pend_cnt all 0 immediately, without waiting for a clock edge.
REQ-038 Macro undefined: pulse while busy -> drop_err=1 for one cycle, pend_cnt=0, no extra handshake.
